// File: rtl/acc_sequencer.sv
// Step-timed accumulator sequencer: loads init, then applies op once per prescaler tick, `steps` times.
// Optional build macro ACC_SEQUENCER_SATURATE_EN clamps add and left shift at 31 instead of wrapping.
module acc_sequencer #(
    parameter int TICK_DIV_W = 25
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] op,
    input  logic [4:0] operand,
    input  logic [4:0] init,
    input  logic [3:0] steps,
    output logic [4:0] acc,
    output logic       busy,
    output logic       done,
    output logic [3:0] remaining
);

    // state  | meaning
    // S_IDLE | waiting for start; request fields captured when start is seen
    // S_LOAD | acc <- init, remaining <- steps, prescaler cleared
    // S_RUN  | prescaler counting; each tick applies op and decrements remaining
    // S_DONE | one-cycle done pulse, then back to idle
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q, op_d;
    logic [4:0]              operand_q, operand_d;
    logic [4:0]              init_q, init_d;
    logic [3:0]              steps_q, steps_d;
    logic [4:0]              acc_q, acc_d;
    logic [3:0]              remaining_q, remaining_d;
    logic [TICK_DIV_W-1:0]   presc_q, presc_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    tick;
    logic [5:0]              sum;
    logic [4:0]              op_result;

    assign tick = &presc_q;
    assign sum  = {1'b0, acc_q} + {1'b0, operand_q};

    always_comb begin
        op_result = acc_q;
        case (op_q)
            2'b00: op_result = acc_q;
`ifdef ACC_SEQUENCER_SATURATE_EN
            2'b01: op_result = sum[5] ? 5'd31 : sum[4:0];
`else
            2'b01: op_result = sum[4:0];
`endif
            2'b10: op_result = acc_q ^ operand_q;
            2'b11: begin
                if (operand_q[0]) begin
                    op_result = {1'b0, acc_q[4:1]};
                end else begin
`ifdef ACC_SEQUENCER_SATURATE_EN
                    op_result = acc_q[4] ? 5'd31 : {acc_q[3:0], 1'b0};
`else
                    op_result = {acc_q[3:0], 1'b0};
`endif
                end
            end
            default: op_result = acc_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        operand_d   = operand_q;
        init_d      = init_q;
        steps_d     = steps_q;
        acc_d       = acc_q;
        remaining_d = remaining_q;
        presc_d     = presc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d      = op;
                    operand_d = operand;
                    init_d    = init;
                    steps_d   = steps;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    remaining_d = 4'd0;
                    state_d     = S_IDLE;
                end else begin
                    acc_d       = init_q;
                    remaining_d = steps_q;
                    presc_d     = '0;
                    state_d     = (steps_q == 4'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    remaining_d = 4'd0;
                    state_d     = S_IDLE;
                end else begin
                    presc_d = presc_q + TICK_DIV_W'(1);
                    if (tick) begin
                        acc_d       = op_result;
                        remaining_d = remaining_q - 4'd1;
                        if (remaining_q == 4'd1) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Outputs are registered, so derive them from the state being entered.
        busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            op_q        <= 2'd0;
            operand_q   <= 5'd0;
            init_q      <= 5'd0;
            steps_q     <= 4'd0;
            acc_q       <= 5'd0;
            remaining_q <= 4'd0;
            presc_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            operand_q   <= operand_d;
            init_q      <= init_d;
            steps_q     <= steps_d;
            acc_q       <= acc_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign acc       = acc_q;
    assign remaining = remaining_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
